// File: rtl/clock_gen_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clock_gen_ctrl_pkg
// Shared definitions for the programmable clock-generator controller:
//   - STATE_W      : width of the controller state encoding
//   - state_t      : controller states (IDLE, RUN_LO, RUN_HI)
//   - CNT_W_DEF    : default width of the phase-length inputs / phase counter
//   - BURST_W_DEF  : default width of the burst-length input / period counter
// -----------------------------------------------------------------------------
package clock_gen_ctrl_pkg;

    localparam int STATE_W     = 2;
    localparam int CNT_W_DEF   = 8;
    localparam int BURST_W_DEF = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        RUN_LO = 2'd1,
        RUN_HI = 2'd2
    } state_t;

endpackage

// File: rtl/clock_gen_ctrl_phase_counter.sv
// -----------------------------------------------------------------------------
// clock_phase_counter
// Loadable down-counter that times one phase (high or low) of the generated
// clock. A load takes priority over counting; the counter holds at zero when
// enabled without a load.
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-high reset
//   load      in   load load_val on the next edge
//   load_val  in   CNT_W value to load (phase length minus one)
//   en        in   decrement enable
//   count     out  CNT_W current count
//   zero      out  count equals zero (phase ends on this cycle's edge)
// -----------------------------------------------------------------------------
module clock_phase_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign count = r_count;
    assign zero  = (r_count == '0);

endmodule

// File: rtl/clock_gen_ctrl.sv
// -----------------------------------------------------------------------------
// clock_gen_ctrl
// Counter-driven square-wave generator. Once started it produces a registered
// clock output with programmable phase lengths, either for a fixed number of
// periods or free-running until stopped. A stop during the high phase is
// deferred so the output never emits a shortened high pulse.
//
// Optional feature macro: CLOCK_GEN_CTRL_DUTY_EN
//   defined   : adds low_period input; low phase = max(low_period,1) cycles
//   undefined : low phase equals the high phase (50% duty)
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   start        in   begin a run (sampled in IDLE only)
//   stop         in   end a run (sampled while busy only)
//   half_period  in   CNT_W high-phase length (and low phase without duty
//                     feature); 0 is treated as 1
//   low_period   in   CNT_W low-phase length (duty feature only)
//   burst        in   BURST_W number of periods; 0 = free-run
//   clk_out      out  generated clock, registered
//   tick         out  one-cycle pulse following each rising toggle
//   busy         out  high while a run is in progress
//   done         out  one-cycle pulse when a run completes
//   dbg_state    out  current controller state
//
// Handshake: start/stop are level requests sampled on the rising clk edge;
// start is accepted only in IDLE with stop low, stop is honoured only while
// busy. There is no ready/ack beyond busy and done.
// -----------------------------------------------------------------------------
module clock_gen_ctrl
    import clock_gen_ctrl_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [CNT_W-1:0]   half_period,
`ifdef CLOCK_GEN_CTRL_DUTY_EN
    input  logic [CNT_W-1:0]   low_period,
`endif
    input  logic [BURST_W-1:0] burst,
    output logic               clk_out,
    output logic               tick,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] dbg_state
);

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    state_t             r_state;
    logic [CNT_W-1:0]   r_h_m1;          // latched high phase length minus one
    logic [BURST_W-1:0] r_burst;         // latched burst length
    logic [BURST_W-1:0] r_period_cnt;    // completed periods, saturating
    logic               r_stop_pending;
    logic               r_clk_out;
    logic               r_tick;
    logic               r_done;
`ifdef CLOCK_GEN_CTRL_DUTY_EN
    logic [CNT_W-1:0]   r_l_m1;          // latched low phase length minus one
`endif

    // ---------------------------------------------------------------------
    // Wires
    // ---------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_h_m1_in;
    logic [CNT_W-1:0]   w_l_m1_in;
    logic [CNT_W-1:0]   w_l_m1;
    logic [CNT_W-1:0]   w_count;
    logic               w_zero;
    logic               w_phase_end;
    logic [BURST_W-1:0] w_period_inc;
    logic               w_burst_done;
    logic               w_stop_req;
    logic               w_start_ok;

    logic               w_load;
    logic [CNT_W-1:0]   w_load_val;
    logic               w_latch;
    logic               w_period_clr;
    logic               w_period_inc_en;
    logic               w_stop_pend_nxt;
    logic               w_clk_out_nxt;
    logic               w_tick_nxt;
    logic               w_done_nxt;

    // Phase lengths of 0 behave as 1, so the reload value clamps at 0.
    assign w_h_m1_in = (half_period == '0) ? '0 : (half_period - CNT_W'(1));
`ifdef CLOCK_GEN_CTRL_DUTY_EN
    assign w_l_m1_in = (low_period == '0) ? '0 : (low_period - CNT_W'(1));
    assign w_l_m1    = r_l_m1;
`else
    assign w_l_m1_in = w_h_m1_in;
    assign w_l_m1    = r_h_m1;
`endif

    assign w_phase_end  = (r_state != IDLE) && w_zero;
    assign w_period_inc = (r_period_cnt == '1) ? r_period_cnt
                                               : (r_period_cnt + BURST_W'(1));
    // Completion is judged on the count the period counter is about to take.
    assign w_burst_done = (r_burst != '0) && (w_period_inc == r_burst);
    // A stop arriving on the very edge that ends the high phase also counts.
    assign w_stop_req   = r_stop_pending || stop;
    assign w_start_ok   = start && !stop;

    // ---------------------------------------------------------------------
    // Phase counter
    // ---------------------------------------------------------------------
    clock_phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .en       (r_state != IDLE),
        .count    (w_count),
        .zero     (w_zero)
    );

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = RUN_LO;
                end
            end
            RUN_LO: begin
                // Stop during the low phase wins over a coincident rise.
                if (stop) begin
                    w_state_nxt = IDLE;
                end else if (w_phase_end) begin
                    w_state_nxt = RUN_HI;
                end
            end
            RUN_HI: begin
                if (w_phase_end) begin
                    if (w_burst_done || w_stop_req) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = RUN_LO;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: output / datapath control logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_load          = 1'b0;
        w_load_val      = r_h_m1;
        w_latch         = 1'b0;
        w_period_clr    = 1'b0;
        w_period_inc_en = 1'b0;
        w_stop_pend_nxt = r_stop_pending;
        w_clk_out_nxt   = r_clk_out;
        w_tick_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        case (r_state)
            IDLE: begin
                w_clk_out_nxt   = 1'b0;
                w_stop_pend_nxt = 1'b0;
                if (w_start_ok) begin
                    w_latch      = 1'b1;
                    w_load       = 1'b1;
                    w_load_val   = w_l_m1_in;   // a run opens with a low phase
                    w_period_clr = 1'b1;
                end
            end
            RUN_LO: begin
                if (stop) begin
                    w_clk_out_nxt   = 1'b0;
                    w_done_nxt      = 1'b1;
                    w_stop_pend_nxt = 1'b0;
                end else if (w_phase_end) begin
                    w_clk_out_nxt = 1'b1;
                    w_tick_nxt    = 1'b1;
                    w_load        = 1'b1;
                    w_load_val    = r_h_m1;
                end
            end
            RUN_HI: begin
                if (stop) begin
                    w_stop_pend_nxt = 1'b1;
                end
                if (w_phase_end) begin
                    w_clk_out_nxt   = 1'b0;
                    w_period_inc_en = 1'b1;
                    w_load          = 1'b1;
                    w_load_val      = w_l_m1;
                    if (w_burst_done || w_stop_req) begin
                        w_done_nxt      = 1'b1;
                        w_stop_pend_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_clk_out_nxt   = 1'b0;
                w_stop_pend_nxt = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Registered outputs, run configuration and period counter
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h_m1         <= '0;
            r_burst        <= '0;
            r_period_cnt   <= '0;
            r_stop_pending <= 1'b0;
            r_clk_out      <= 1'b0;
            r_tick         <= 1'b0;
            r_done         <= 1'b0;
`ifdef CLOCK_GEN_CTRL_DUTY_EN
            r_l_m1         <= '0;
`endif
        end else begin
            if (w_latch) begin
                r_h_m1  <= w_h_m1_in;
                r_burst <= burst;
`ifdef CLOCK_GEN_CTRL_DUTY_EN
                r_l_m1  <= w_l_m1_in;
`endif
            end
            if (w_period_clr) begin
                r_period_cnt <= '0;
            end else if (w_period_inc_en) begin
                r_period_cnt <= w_period_inc;
            end
            r_stop_pending <= w_stop_pend_nxt;
            r_clk_out      <= w_clk_out_nxt;
            r_tick         <= w_tick_nxt;
            r_done         <= w_done_nxt;
        end
    end

    assign clk_out   = r_clk_out;
    assign tick      = r_tick;
    assign done      = r_done;
    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_clock_gen_ctrl.sv
module tb_clock_gen_ctrl;
  import clock_gen_ctrl_pkg::*;

  localparam int CNT_W   = 8;
  localparam int BURST_W = 8;

  logic               clk;
  logic               reset;
  logic               start;
  logic               stop;
  logic [CNT_W-1:0]   half_period;
  logic [CNT_W-1:0]   low_period;
  logic [BURST_W-1:0] burst;
  logic               clk_out;
  logic               tick;
  logic               busy;
  logic               done;
  logic [STATE_W-1:0] dbg_state;

  int n_cmp;
  int n_err;

  clock_gen_ctrl #(
    .CNT_W   (CNT_W),
    .BURST_W (BURST_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .half_period (half_period),
`ifdef CLOCK_GEN_CTRL_DUTY_EN
    .low_period  (low_period),
`endif
    .burst       (burst),
    .clk_out     (clk_out),
    .tick        (tick),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checker
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver: advance one edge, sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a run and checks every cycle against the ideal waveform: with low
  // length L and high length H (P = L+H), after edge k+m the output is high
  // for (m mod P) in [L, P-1], tick marks m mod P == L, and a burst of N ends
  // with done exactly at m = N*P. poke_m injects a stray start with different
  // settings just before edge k+poke_m.
  task automatic run_burst(input string tag, input int h, input int l, input int n,
                           input int steps, input int poke_m);
    int hm, lm, p, pos;
    logic e_clk, e_tick, e_done, e_busy;
    hm = (h == 0) ? 1 : h;
`ifdef CLOCK_GEN_CTRL_DUTY_EN
    lm = (l == 0) ? 1 : l;
`else
    lm = hm;
`endif
    p = hm + lm;
    half_period = CNT_W'(h);
    low_period  = CNT_W'(l);
    burst       = BURST_W'(n);
    start       = 1'b1;
    step();
    start = 1'b0;
    check_val($sformatf("%s m=0 busy", tag), busy, 1);
    check_val($sformatf("%s m=0 done", tag), done, 0);
    check_val($sformatf("%s m=0 clk_out", tag), clk_out, 0);
    for (int m = 1; m <= steps; m++) begin
      if (m == poke_m) begin
        start       = 1'b1;
        half_period = CNT_W'(7);
        low_period  = CNT_W'(7);
        burst       = BURST_W'(5);
      end
      step();
      start = 1'b0;
      pos = m % p;
      if (n != 0 && m >= n * p) begin
        e_clk  = 1'b0;
        e_tick = 1'b0;
        e_busy = 1'b0;
        e_done = (m == n * p);
      end else begin
        e_clk  = (pos >= lm);
        e_tick = (pos == lm);
        e_busy = 1'b1;
        e_done = 1'b0;
      end
      check_val($sformatf("%s m=%0d clk_out", tag, m), clk_out, e_clk);
      check_val($sformatf("%s m=%0d tick", tag, m), tick, e_tick);
      check_val($sformatf("%s m=%0d done", tag, m), done, e_done);
      check_val($sformatf("%s m=%0d busy", tag, m), busy, e_busy);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset       = 1'b1;
    start       = 1'b0;
    stop        = 1'b0;
    half_period = '0;
    low_period  = '0;
    burst       = '0;

    // reset state
    step();
    step();
    check_val("rst clk_out", clk_out, 0);
    check_val("rst tick", tick, 0);
    check_val("rst busy", busy, 0);
    check_val("rst done", done, 0);
    check_val("rst state", dbg_state, IDLE);
    reset = 1'b0;
    step();
    step();

    // H=3 N=2: rises after k+3,k+9, falls after k+6,k+12, done at k+12.
    // A start sampled in the done cycle is accepted immediately.
    run_burst("h3n2", 3, 3, 2, 12, -1);
    run_burst("restart_h1n1", 1, 1, 1, 3, -1);

    // half_period=0 behaves as H=1
    run_burst("h0n1", 0, 0, 1, 3, -1);

    // start mid-run with other settings is ignored
    run_burst("poke", 2, 2, 2, 10, 3);

    // start and stop together in IDLE: nothing starts
    half_period = CNT_W'(2);
    burst       = BURST_W'(1);
    start       = 1'b1;
    stop        = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check_val("both busy", busy, 0);
    check_val("both state", dbg_state, IDLE);
    step();
    check_val("both done", done, 0);

    // free-run H=4, stop while high: high phase completes its 4 cycles
    half_period = CNT_W'(4);
    burst       = BURST_W'(0);
    start       = 1'b1;
    step();
    start = 1'b0;
    for (int m = 1; m <= 5; m++) step();
    check_val("stophi m5 clk_out", clk_out, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_val("stophi m6 clk_out", clk_out, 1);
    check_val("stophi m6 busy", busy, 1);
    check_val("stophi m6 done", done, 0);
    step();
    check_val("stophi m7 clk_out", clk_out, 1);
    check_val("stophi m7 done", done, 0);
    step();
    check_val("stophi m8 clk_out", clk_out, 0);
    check_val("stophi m8 done", done, 1);
    check_val("stophi m8 busy", busy, 0);
    check_val("stophi m8 tick", tick, 0);
    step();
    check_val("stophi m9 done", done, 0);
    check_val("stophi m9 tick", tick, 0);
    check_val("stophi m9 clk_out", clk_out, 0);

    // free-run H=4, stop during low phase: done the cycle after edge j
    half_period = CNT_W'(4);
    burst       = BURST_W'(0);
    start       = 1'b1;
    step();
    start = 1'b0;
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_val("stoplo done", done, 1);
    check_val("stoplo busy", busy, 0);
    check_val("stoplo clk_out", clk_out, 0);
    check_val("stoplo state", dbg_state, IDLE);
    step();
    check_val("stoplo done2", done, 0);

    // asynchronous reset while high
    half_period = CNT_W'(3);
    burst       = BURST_W'(0);
    start       = 1'b1;
    step();
    start = 1'b0;
    for (int m = 1; m <= 3; m++) step();
    check_val("arst pre clk_out", clk_out, 1);
    check_val("arst pre tick", tick, 1);
    #2;
    reset = 1'b1;
    #1;
    check_val("arst clk_out", clk_out, 0);
    check_val("arst busy", busy, 0);
    check_val("arst tick", tick, 0);
    check_val("arst done", done, 0);
    step();
    reset = 1'b0;
    step();
    check_val("arst post done", done, 0);
    check_val("arst post busy", busy, 0);
    run_burst("after_rst", 2, 2, 1, 5, -1);

`ifdef CLOCK_GEN_CTRL_DUTY_EN
    // H=2 L=4 N=3: rises after 4,10,16, falls after 6,12,18
    run_burst("duty", 2, 4, 3, 20, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
